// File: rtl/sap_ctrl_pkg.sv
// Shared encodings for the 8-bit bus computer control sequencer:
// bus source codes, opcodes, ALU operations and sequencer states.
package sap_ctrl_pkg;

  // Bus source select codes driven onto the shared bus
  typedef enum logic [3:0] {
    SRC_PC   = 4'h0,
    SRC_ACC  = 4'h1,
    SRC_BREG = 4'h2,
    SRC_ALU  = 4'h3,
    SRC_MAR  = 4'h4,
    SRC_MEM  = 4'h5,
    SRC_IR   = 4'h6,
    SRC_NONE = 4'hF
  } src_sel_e;

  // Instruction opcodes (IR[7:4])
  typedef enum logic [3:0] {
    OP_LDA  = 4'h0,
    OP_ADD  = 4'h1,
    OP_SUB  = 4'h2,
    OP_STA  = 4'h3,
    OP_JMP  = 4'h4,
    OP_AND  = 4'h5,
    OP_OR   = 4'h6,
    OP_XOR  = 4'h7,
    OP_INC  = 4'h8,
    OP_DEC  = 4'h9,
    OP_NOT  = 4'hA,
    OP_NOPB = 4'hB,
    OP_NOPC = 4'hC,
    OP_NOPD = 4'hD,
    OP_OUT  = 4'hE,
    OP_HLT  = 4'hF
  } opcode_e;

  // ALU operation codes
  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_DEC = 3'b010,
    ALU_INC = 3'b011,
    ALU_NOT = 3'b100,
    ALU_AND = 3'b101,
    ALU_OR  = 3'b110,
    ALU_XOR = 3'b111
  } alu_op_e;

  // Sequencer states; the encoding doubles as the TSTATE debug output
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_T1   = 3'd1,
    ST_T2   = 3'd2,
    ST_T3   = 3'd3,
    ST_T4   = 3'd4,
    ST_T5   = 3'd5,
    ST_T6   = 3'd6,
    ST_HALT = 3'd7
  } seq_state_e;

  // ALU operation implied by an opcode; non-ALU opcodes give ADD (000)
  function automatic alu_op_e alu_op_of(input opcode_e op);
    alu_op_e res;
    res = ALU_ADD;
    case (op)
      OP_SUB:  res = ALU_SUB;
      OP_DEC:  res = ALU_DEC;
      OP_INC:  res = ALU_INC;
      OP_NOT:  res = ALU_NOT;
      OP_AND:  res = ALU_AND;
      OP_OR:   res = ALU_OR;
      OP_XOR:  res = ALU_XOR;
      default: res = ALU_ADD;
    endcase
    return res;
  endfunction

  // Opcodes whose T4 cycle is an EEPROM access
  function automatic logic is_mem_op(input opcode_e op);
    logic res;
    res = 1'b0;
    case (op)
      OP_LDA, OP_ADD, OP_SUB, OP_STA, OP_AND, OP_OR, OP_XOR: res = 1'b1;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles spent waiting on the EEPROM handshake and flags the
// edge at which the wait reaches MEM_TMO cycles.
module mem_wait_timer #(
  parameter int unsigned      TMO_W   = 20,
  parameter logic [TMO_W-1:0] MEM_TMO = TMO_W'(20'hFFFFF)
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_cnt_en,
  output logic o_expired
);

  localparam logic [TMO_W-1:0] LAST_CNT = MEM_TMO - TMO_W'(1);

  logic [TMO_W-1:0] r_count;

  // Wait-cycle counter: clear has priority and the count never passes MEM_TMO
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_cnt_en && (r_count != MEM_TMO)) begin
      r_count <= r_count + TMO_W'(1);
    end
  end

  // High in the wait cycle whose closing edge brings the count to MEM_TMO
  assign o_expired = i_cnt_en && (r_count == LAST_CNT);

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/decode/execute controller for the 8-bit bus computer.
// Each cycle selects one bus source and pulses destination write strobes;
// EEPROM accesses handshake via MEM_REQ/MEM_DONE with a timeout that
// halts the machine and raises a sticky error.
module instr_sequencer
  import sap_ctrl_pkg::*;
#(
  parameter int unsigned      TMO_W   = 20,
  parameter logic [TMO_W-1:0] MEM_TMO = TMO_W'(20'hFFFFF)
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_run,
  input  logic [7:0] i_bus_in,
  input  logic       i_mem_done,
  output logic [3:0] o_src_sel,
  output logic       o_we_pc,
  output logic       o_we_acc,
  output logic       o_we_breg,
  output logic       o_we_mar,
  output logic       o_we_ir,
  output logic       o_we_or,
  output logic       o_pc_inc,
  output logic [2:0] o_alu_op,
  output logic       o_mem_req,
  output logic       o_mem_wr,
  output logic       o_halted,
  output logic       o_err,
  output logic [2:0] o_tstate
);

  seq_state_e r_state;
  seq_state_e w_state_next;
  logic [7:0] r_ir;
  logic       r_err;

  opcode_e    w_op;
  src_sel_e   w_src;
  logic       w_we_pc;
  logic       w_we_acc;
  logic       w_we_breg;
  logic       w_we_mar;
  logic       w_we_ir;
  logic       w_we_or;
  logic       w_pc_inc;
  logic       w_ir_load;
  logic       w_err_set;
  logic       w_mem_cycle;
  logic       w_tmr_clear;
  logic       w_tmr_cnt_en;
  logic       w_tmr_expired;

  assign w_op = opcode_e'(r_ir[7:4]);

  // Memory request is a pure function of state and latched opcode, so an
  // async reset drops it immediately; it falls the cycle after DONE
  // because DONE always moves the state out of T2/T4.
  assign w_mem_cycle = (r_state == ST_T2) ||
                       ((r_state == ST_T4) && is_mem_op(w_op));

  // Timer restarts whenever a fresh T2/T4 visit begins and counts only
  // cycles still waiting for DONE.
  assign w_tmr_clear  = (w_state_next != r_state) &&
                        ((w_state_next == ST_T2) || (w_state_next == ST_T4));
  assign w_tmr_cnt_en = w_mem_cycle && !i_mem_done;

  mem_wait_timer #(
    .TMO_W   (TMO_W),
    .MEM_TMO (MEM_TMO)
  ) u_mem_wait_timer (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clear   (w_tmr_clear),
    .i_cnt_en  (w_tmr_cnt_en),
    .o_expired (w_tmr_expired)
  );

  // State, instruction register and sticky error flag
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_ir    <= 8'h00;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_ir_load) begin
        r_ir <= i_bus_in;
      end
      if (w_err_set) begin
        r_err <= 1'b1;
      end
    end
  end

  // Next-state and per-cycle bus source / strobe decode
  always_comb begin
    w_state_next = r_state;
    w_src        = SRC_NONE;
    w_we_pc      = 1'b0;
    w_we_acc     = 1'b0;
    w_we_breg    = 1'b0;
    w_we_mar     = 1'b0;
    w_we_ir      = 1'b0;
    w_we_or      = 1'b0;
    w_pc_inc     = 1'b0;
    w_ir_load    = 1'b0;
    w_err_set    = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (i_run) begin
          w_state_next = ST_T1;
        end
      end

      ST_T1: begin
        w_src        = SRC_PC;
        w_we_mar     = 1'b1;
        w_state_next = ST_T2;
      end

      ST_T2: begin
        if (i_mem_done) begin
          w_src        = SRC_MEM;
          w_we_ir      = 1'b1;
          w_pc_inc     = 1'b1;
          w_ir_load    = 1'b1;
          w_state_next = ST_T3;
        end else if (w_tmr_expired) begin
          w_err_set    = 1'b1;
          w_state_next = ST_HALT;
        end
      end

      ST_T3: begin
        case (w_op)
          OP_LDA, OP_ADD, OP_SUB, OP_STA, OP_AND, OP_OR, OP_XOR: begin
            w_src        = SRC_IR;
            w_we_mar     = 1'b1;
            w_state_next = ST_T4;
          end
          OP_JMP: begin
            w_src        = SRC_IR;
            w_we_pc      = 1'b1;
            w_state_next = ST_T1;
          end
          OP_OUT: begin
            w_src        = SRC_ACC;
            w_we_or      = 1'b1;
            w_state_next = ST_T1;
          end
          OP_HLT: begin
            w_state_next = ST_HALT;
          end
          // Unary ops give the ALU a cycle to register its result
          OP_INC, OP_DEC, OP_NOT: begin
            w_state_next = ST_T4;
          end
          default: begin
            w_state_next = ST_T1;
          end
        endcase
      end

      ST_T4: begin
        if (is_mem_op(w_op)) begin
          // STA keeps the accumulator on the bus for the whole write
          if (w_op == OP_STA) begin
            w_src = SRC_ACC;
          end
          if (i_mem_done) begin
            if (w_op == OP_LDA) begin
              w_src        = SRC_MEM;
              w_we_acc     = 1'b1;
              w_state_next = ST_T1;
            end else if (w_op == OP_STA) begin
              w_state_next = ST_T1;
            end else begin
              w_src        = SRC_MEM;
              w_we_breg    = 1'b1;
              w_state_next = ST_T5;
            end
          end else if (w_tmr_expired) begin
            w_err_set    = 1'b1;
            w_state_next = ST_HALT;
          end
        end else if ((w_op == OP_INC) || (w_op == OP_DEC) || (w_op == OP_NOT)) begin
          w_src        = SRC_ALU;
          w_we_acc     = 1'b1;
          w_state_next = ST_T1;
        end else begin
          w_state_next = ST_T1;
        end
      end

      ST_T5: begin
        w_state_next = ST_T6;
      end

      ST_T6: begin
        w_src        = SRC_ALU;
        w_we_acc     = 1'b1;
        w_state_next = ST_T1;
      end

      ST_HALT: begin
        w_state_next = ST_HALT;
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase

    // Instructions always finish; RUN is only sampled at the next fetch
    if ((w_state_next == ST_T1) && !i_run) begin
      w_state_next = ST_IDLE;
    end
  end

  assign o_src_sel = w_src;
  assign o_we_pc   = w_we_pc;
  assign o_we_acc  = w_we_acc;
  assign o_we_breg = w_we_breg;
  assign o_we_mar  = w_we_mar;
  assign o_we_ir   = w_we_ir;
  assign o_we_or   = w_we_or;
  assign o_pc_inc  = w_pc_inc;
  assign o_alu_op  = alu_op_of(w_op);
  assign o_mem_req = w_mem_cycle;
  assign o_mem_wr  = (r_state == ST_T4) && (w_op == OP_STA);
  assign o_halted  = (r_state == ST_HALT);
  assign o_err     = r_err;
  assign o_tstate  = r_state;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: one task per scenario, each walking
// the sequencer cycle by cycle against hand-computed outputs.
module tb_instr_sequencer;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic       i_run;
  logic [7:0] i_bus_in;
  logic       i_mem_done;
  logic [3:0] o_src_sel;
  logic       o_we_pc, o_we_acc, o_we_breg, o_we_mar, o_we_ir, o_we_or;
  logic       o_pc_inc;
  logic [2:0] o_alu_op;
  logic       o_mem_req, o_mem_wr, o_halted, o_err;
  logic [2:0] o_tstate;

  // {tstate, src, we_pc/acc/breg/mar/ir/or, pc_inc, mem_req, mem_wr, alu_op}
  logic [18:0] obs;
  logic [18:0] exp;
  int n_total = 0;
  int n_pass  = 0;
  int pcinc_cnt = 0;

  assign obs = {o_tstate, o_src_sel, o_we_pc, o_we_acc, o_we_breg, o_we_mar,
                o_we_ir, o_we_or, o_pc_inc, o_mem_req, o_mem_wr, o_alu_op};

  always #5 i_clk = ~i_clk;

  instr_sequencer #(
    .TMO_W   (20),
    .MEM_TMO (20'd16)
  ) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_run      (i_run),
    .i_bus_in   (i_bus_in),
    .i_mem_done (i_mem_done),
    .o_src_sel  (o_src_sel),
    .o_we_pc    (o_we_pc),
    .o_we_acc   (o_we_acc),
    .o_we_breg  (o_we_breg),
    .o_we_mar   (o_we_mar),
    .o_we_ir    (o_we_ir),
    .o_we_or    (o_we_or),
    .o_pc_inc   (o_pc_inc),
    .o_alu_op   (o_alu_op),
    .o_mem_req  (o_mem_req),
    .o_mem_wr   (o_mem_wr),
    .o_halted   (o_halted),
    .o_err      (o_err),
    .o_tstate   (o_tstate)
  );

  // Drive one cycle's inputs at the falling edge, then let outputs settle
  task automatic cyc(input logic run, input logic done, input logic [7:0] bus);
    @(negedge i_clk);
    i_run      = run;
    i_mem_done = done;
    i_bus_in   = bus;
    #1;
    pcinc_cnt += int'(o_pc_inc);
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_run = 1'b0; i_mem_done = 1'b0; i_bus_in = 8'h00;
    @(negedge i_clk); #1;
    exp = {3'd0, 4'hF, 6'b000000, 3'b000, 3'b000};
    n_total++;
    if (obs !== exp) $display("FAIL reset_outputs got=%b want=%b", obs, exp); else n_pass++;
    n_total++;
    if ({o_halted, o_err} !== 2'b00) $display("FAIL reset_flags got=%b want=00", {o_halted, o_err}); else n_pass++;
    cyc(1'b1, 1'b1, 8'hFF);
    n_total++;
    if (o_tstate !== 3'd0) $display("FAIL reset_holds_idle got=%0d want=0", o_tstate); else n_pass++;
    i_run = 1'b0; i_mem_done = 1'b0; i_rst = 1'b0;
    $display("tb: reset released");
  endtask

  task automatic test_lda();
    pcinc_cnt = 0;
    cyc(1'b1, 1'b0, 8'h00);
    exp = {3'd0, 4'hF, 6'b000000, 3'b000, 3'b000};
    n_total++;
    if (obs !== exp) $display("FAIL lda_idle got=%b want=%b", obs, exp); else n_pass++;
    cyc(1'b1, 1'b0, 8'h00);
    exp = {3'd1, 4'h0, 6'b000100, 3'b000, 3'b000};
    n_total++;
    if (obs !== exp) $display("FAIL lda_t1 got=%b want=%b", obs, exp); else n_pass++;
    cyc(1'b1, 1'b0, 8'h00);
    exp = {3'd2, 4'hF, 6'b000000, 3'b010, 3'b000};
    n_total++;
    if (obs !== exp) $display("FAIL lda_t2_wait got=%b want=%b", obs, exp); else n_pass++;
    cyc(1'b1, 1'b0, 8'h00);
    cyc(1'b1, 1'b1, 8'h07);
    exp = {3'd2, 4'h5, 6'b000010, 3'b110, 3'b000};
    n_total++;
    if (obs !== exp) $display("FAIL lda_t2_done got=%b want=%b", obs, exp); else n_pass++;
    cyc(1'b1, 1'b0, 8'h00);
    exp = {3'd3, 4'h6, 6'b000100, 3'b000, 3'b000};
    n_total++;
    if (obs !== exp) $display("FAIL lda_t3 got=%b want=%b", obs, exp); else n_pass++;
    cyc(1'b1, 1'b0, 8'h00);
    exp = {3'd4, 4'hF, 6'b000000, 3'b010, 3'b000};
    n_total++;
    if (obs !== exp) $display("FAIL lda_t4_wait got=%b want=%b", obs, exp); else n_pass++;
    cyc(1'b1, 1'b0, 8'h00);
    cyc(1'b0, 1'b1, 8'h2A);
    exp = {3'd4, 4'h5, 6'b010000, 3'b010, 3'b000};
    n_total++;
    if (obs !== exp) $display("FAIL lda_t4_done got=%b want=%b", obs, exp); else n_pass++;
    cyc(1'b0, 1'b0, 8'h00);
    exp = {3'd0, 4'hF, 6'b000000, 3'b000, 3'b000};
    n_total++;
    if (obs !== exp) $display("FAIL lda_to_idle got=%b want=%b", obs, exp); else n_pass++;
    n_total++;
    if (pcinc_cnt !== 1) $display("FAIL lda_pc_inc_pulses got=%0d want=1", pcinc_cnt); else n_pass++;
    $display("tb: LDA 8'h07, mem=8'h2A");
  endtask

  task automatic test_add();
    cyc(1'b1, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, 8'h00);
    cyc(1'b1, 1'b1, 8'h18);
    cyc(1'b1, 1'b0, 8'h00);
    exp = {3'd3, 4'h6, 6'b000100, 3'b000, 3'b000};
    n_total++;
    if (obs !== exp) $display("FAIL add_t3 got=%b want=%b", obs, exp); else n_pass++;
    cyc(1'b1, 1'b1, 8'h05);
    exp = {3'd4, 4'h5, 6'b001000, 3'b010, 3'b000};
    n_total++;
    if (obs !== exp) $display("FAIL add_t4_done got=%b want=%b", obs, exp); else n_pass++;
    cyc(1'b1, 1'b0, 8'h00);
    exp = {3'd5, 4'hF, 6'b000000, 3'b000, 3'b000};
    n_total++;
    if (obs !== exp) $display("FAIL add_t5 got=%b want=%b", obs, exp); else n_pass++;
    cyc(1'b0, 1'b0, 8'h00);
    exp = {3'd6, 4'h3, 6'b010000, 3'b000, 3'b000};
    n_total++;
    if (obs !== exp) $display("FAIL add_t6 got=%b want=%b", obs, exp); else n_pass++;
    cyc(1'b0, 1'b0, 8'h00);
    n_total++;
    if (o_tstate !== 3'd0) $display("FAIL add_to_idle got=%0d want=0", o_tstate); else n_pass++;
    $display("tb: ADD 8'h18, mem=8'h05");
  endtask

  task automatic test_jmp();
    cyc(1'b1, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, 8'h00);
    cyc(1'b1, 1'b1, 8'h4C);
    // A stray DONE in T3 must be ignored
    cyc(1'b1, 1'b1, 8'hAA);
    exp = {3'd3, 4'h6, 6'b100000, 3'b000, 3'b000};
    n_total++;
    if (obs !== exp) $display("FAIL jmp_t3 got=%b want=%b", obs, exp); else n_pass++;
    cyc(1'b1, 1'b0, 8'h00);
    exp = {3'd1, 4'h0, 6'b000100, 3'b000, 3'b000};
    n_total++;
    if (obs !== exp) $display("FAIL jmp_next_t1 got=%b want=%b", obs, exp); else n_pass++;
    cyc(1'b1, 1'b1, 8'hB0);
    cyc(1'b0, 1'b0, 8'h00);
    exp = {3'd3, 4'hF, 6'b000000, 3'b000, 3'b000};
    n_total++;
    if (obs !== exp) $display("FAIL nop_t3 got=%b want=%b", obs, exp); else n_pass++;
    cyc(1'b0, 1'b0, 8'h00);
    n_total++;
    if (o_tstate !== 3'd0) $display("FAIL nop_to_idle got=%0d want=0", o_tstate); else n_pass++;
    $display("tb: JMP 8'h4C then NOP 8'hB0");
  endtask

  task automatic test_back_to_back();
    cyc(1'b1, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, 8'h00);
    cyc(1'b1, 1'b1, 8'h85);
    cyc(1'b1, 1'b0, 8'h00);
    exp = {3'd3, 4'hF, 6'b000000, 3'b000, 3'b011};
    n_total++;
    if (obs !== exp) $display("FAIL inc_t3 got=%b want=%b", obs, exp); else n_pass++;
    cyc(1'b1, 1'b0, 8'h00);
    exp = {3'd4, 4'h3, 6'b010000, 3'b000, 3'b011};
    n_total++;
    if (obs !== exp) $display("FAIL inc_t4 got=%b want=%b", obs, exp); else n_pass++;
    cyc(1'b1, 1'b0, 8'h00);
    exp = {3'd1, 4'h0, 6'b000100, 3'b000, 3'b011};
    n_total++;
    if (obs !== exp) $display("FAIL b2b_t1 got=%b want=%b", obs, exp); else n_pass++;
    cyc(1'b1, 1'b1, 8'h7A);
    cyc(1'b1, 1'b0, 8'h00);
    exp = {3'd3, 4'h6, 6'b000100, 3'b000, 3'b111};
    n_total++;
    if (obs !== exp) $display("FAIL xor_t3 got=%b want=%b", obs, exp); else n_pass++;
    cyc(1'b1, 1'b1, 8'h33);
    exp = {3'd4, 4'h5, 6'b001000, 3'b010, 3'b111};
    n_total++;
    if (obs !== exp) $display("FAIL xor_t4_done got=%b want=%b", obs, exp); else n_pass++;
    cyc(1'b1, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, 8'h00);
    exp = {3'd6, 4'h3, 6'b010000, 3'b000, 3'b111};
    n_total++;
    if (obs !== exp) $display("FAIL xor_t6 got=%b want=%b", obs, exp); else n_pass++;
    // OUT directly after XOR
    cyc(1'b1, 1'b0, 8'h00);
    cyc(1'b1, 1'b1, 8'hE0);
    cyc(1'b0, 1'b0, 8'h00);
    exp = {3'd3, 4'h1, 6'b000001, 3'b000, 3'b000};
    n_total++;
    if (obs !== exp) $display("FAIL out_t3 got=%b want=%b", obs, exp); else n_pass++;
    cyc(1'b0, 1'b0, 8'h00);
    n_total++;
    if (o_tstate !== 3'd0) $display("FAIL out_to_idle got=%0d want=0", o_tstate); else n_pass++;
    $display("tb: INC 8'h85, XOR 8'h7A, OUT 8'hE0 back to back");
  endtask

  task automatic test_hlt();
    int bad;
    cyc(1'b1, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, 8'h00);
    cyc(1'b1, 1'b1, 8'hF0);
    cyc(1'b1, 1'b0, 8'h00);
    exp = {3'd3, 4'hF, 6'b000000, 3'b000, 3'b000};
    n_total++;
    if (obs !== exp) $display("FAIL hlt_t3 got=%b want=%b", obs, exp); else n_pass++;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      cyc(i[0], i[1], 8'h12);
      if (!(o_halted === 1'b1 && o_tstate === 3'd7 && o_src_sel === 4'hF && o_mem_req === 1'b0))
        bad++;
    end
    n_total++;
    if (bad !== 0) $display("FAIL hlt_stays got=%0d bad cycles want=0", bad); else n_pass++;
    i_rst = 1'b1;
    #1;
    n_total++;
    if ({o_halted, o_tstate} !== 4'b0000) $display("FAIL hlt_reset got=%b want=0000", {o_halted, o_tstate}); else n_pass++;
    @(negedge i_clk);
    i_run = 1'b0; i_mem_done = 1'b0; i_rst = 1'b0;
    $display("tb: HLT 8'hF0, cleared by reset");
  endtask

  task automatic test_timeout();
    int bad;
    cyc(1'b1, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, 8'h00);
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 1'b0, 8'h00);
      if (!(o_tstate === 3'd2 && o_mem_req === 1'b1 && o_err === 1'b0))
        bad++;
    end
    n_total++;
    if (bad !== 0) $display("FAIL tmo_wait_cycles got=%0d bad cycles want=0", bad); else n_pass++;
    // DONE arriving after the timeout must be ignored
    cyc(1'b1, 1'b1, 8'h55);
    exp = {3'd7, 4'hF, 6'b000000, 3'b000, 3'b000};
    n_total++;
    if (obs !== exp) $display("FAIL tmo_halt got=%b want=%b", obs, exp); else n_pass++;
    n_total++;
    if ({o_halted, o_err} !== 2'b11) $display("FAIL tmo_flags got=%b want=11", {o_halted, o_err}); else n_pass++;
    cyc(1'b0, 1'b0, 8'h00);
    n_total++;
    if (o_err !== 1'b1) $display("FAIL tmo_err_sticky got=%b want=1", o_err); else n_pass++;
    i_rst = 1'b1;
    #1;
    n_total++;
    if ({o_err, o_halted} !== 2'b00) $display("FAIL tmo_reset got=%b want=00", {o_err, o_halted}); else n_pass++;
    @(negedge i_clk);
    i_run = 1'b0; i_mem_done = 1'b0; i_rst = 1'b0;
    $display("tb: fetch timeout after 16 wait cycles");
  endtask

  task automatic test_sta_reset();
    cyc(1'b1, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, 8'h00);
    cyc(1'b1, 1'b1, 8'h3A);
    cyc(1'b1, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, 8'h00);
    exp = {3'd4, 4'h1, 6'b000000, 3'b011, 3'b000};
    n_total++;
    if (obs !== exp) $display("FAIL sta_t4_wait got=%b want=%b", obs, exp); else n_pass++;
    cyc(1'b1, 1'b1, 8'h00);
    exp = {3'd4, 4'h1, 6'b000000, 3'b011, 3'b000};
    n_total++;
    if (obs !== exp) $display("FAIL sta_t4_done got=%b want=%b", obs, exp); else n_pass++;
    cyc(1'b1, 1'b0, 8'h00);
    exp = {3'd1, 4'h0, 6'b000100, 3'b000, 3'b000};
    n_total++;
    if (obs !== exp) $display("FAIL sta_after_done got=%b want=%b", obs, exp); else n_pass++;
    $display("tb: STA 8'h3A completed");
    // Second STA, interrupted by reset while waiting for DONE
    cyc(1'b1, 1'b1, 8'h3A);
    cyc(1'b1, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, 8'h00);
    i_rst = 1'b1;
    #1;
    n_total++;
    if ({o_mem_req, o_mem_wr, o_tstate} !== 5'b00000)
      $display("FAIL sta_reset_async got=%b want=00000", {o_mem_req, o_mem_wr, o_tstate});
    else n_pass++;
    @(negedge i_clk);
    i_run = 1'b0; i_mem_done = 1'b0; i_rst = 1'b0;
    cyc(1'b0, 1'b0, 8'h00);
    exp = {3'd0, 4'hF, 6'b000000, 3'b000, 3'b000};
    n_total++;
    if (obs !== exp) $display("FAIL sta_reset_idle got=%b want=%b", obs, exp); else n_pass++;
    $display("tb: STA 8'h3A interrupted by reset");
  endtask

  initial begin
    test_reset();
    test_lda();
    test_add();
    test_jmp();
    test_back_to_back();
    test_hlt();
    test_timeout();
    test_sta_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired after %0t", $time);
    $fatal(1);
  end

endmodule
